// File: rtl/fm_phase_discriminator.sv
// fm_phase_discriminator
//   Turns the CORDIC polar stream (magnitude in the low half, angle in the high half) into
//   instantaneous frequency. Each sample after the first in a packet contributes one delta,
//   which is the wrapped difference between consecutive angles. DECIM deltas are summed and
//   divided by DECIM (arithmetic shift) to give one output word.
//
// Ports
//   s00_axis_aclk    : single clock
//   s00_axis_areset  : synchronous active-high reset
//   s00_axis_t*      : AXI-Stream slave carrying CORDIC words (tstrb ignored)
//   m00_axis_t*      : AXI-Stream master carrying the averaged delta, sign-extended
//                      (tstrb constant all-ones)
//
// A single output register holds at most one word; the input is ready whenever that
// register is empty or is being drained in the same cycle, so sink backpressure reaches
// the source combinationally.

module fm_phase_discriminator #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ANGLE_LSB              = 16,
  parameter int unsigned ANGLE_W                = 16,
  parameter int unsigned DECIM                  = 4
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

  localparam int unsigned LOG2_DECIM = $clog2(DECIM);
  // LOG2_DECIM guard bits let DECIM full-scale deltas sum without overflow.
  localparam int unsigned ACC_W      = ANGLE_W + LOG2_DECIM;
  localparam int unsigned CNT_W      = LOG2_DECIM + 1;

  typedef enum logic [0:0] {
    StPrime,
    StAccum
  } state_e;

  state_e                            state_q, state_d;
  logic signed [ANGLE_W-1:0]         prev_q, prev_d;
  logic signed [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              out_valid_q, out_valid_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                              out_last_q, out_last_d;

  logic                              in_hs;
  logic                              out_hs;
  logic                              emit;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] emit_data;
  logic signed [ANGLE_W-1:0]         a_cur;
  logic signed [ANGLE_W-1:0]         delta;
  logic signed [ACC_W-1:0]           acc_next;
  logic signed [ACC_W-1:0]           acc_shift;

  // Magnitude bits and tstrb carry nothing this block needs.
  logic unused_in;
  assign unused_in = ^{s00_axis_tstrb, s00_axis_tdata};

  assign s00_axis_tready = ~out_valid_q | m00_axis_tready;
  assign in_hs           = s00_axis_tvalid & s00_axis_tready;
  assign out_hs          = out_valid_q & m00_axis_tready;

  assign a_cur     = s00_axis_tdata[ANGLE_LSB +: ANGLE_W];
  // Truncation to ANGLE_W bits gives the natural wrap across +/-pi.
  assign delta     = a_cur - prev_q;
  assign acc_next  = acc_q + ACC_W'(delta);
  // Partial groups flushed by tlast still divide by DECIM, not by the sample count.
  assign acc_shift = acc_next >>> LOG2_DECIM;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    emit        = 1'b0;
    emit_data   = '0;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (in_hs) begin
      prev_d = a_cur;
      case (state_q)
        StPrime: begin
          // First sample of a packet only establishes the reference angle.
          if (s00_axis_tlast) begin
            emit = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
        StAccum: begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q == CNT_W'(DECIM - 1)) || s00_axis_tlast) begin
            emit      = 1'b1;
            emit_data = C_M00_AXIS_TDATA_WIDTH'(acc_shift);
            acc_d     = '0;
            cnt_d     = '0;
            if (s00_axis_tlast) begin
              state_d = StPrime;
            end
          end
        end
        default: state_d = StPrime;
      endcase
    end

    // A new word may load in the same cycle the old one drains.
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_last_d  = s00_axis_tlast;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= StPrime;
      prev_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tlast  = out_last_q;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Scoreboard bench for fm_phase_discriminator. An input monitor feeds every accepted sample
// into a packet-level reference model and queues the expected words; an output monitor pops
// and compares on every output handshake. Inputs change 1 ns after posedge, both monitors
// sample on negedge.

module tb_fm_phase_discriminator;

  localparam int DECIM = 4;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        s00_axis_tvalid = 1'b0;
  logic        s00_axis_tready;
  logic [31:0] s00_axis_tdata = '0;
  logic        s00_axis_tlast = 1'b0;
  logic [3:0]  s00_axis_tstrb = '0;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready = 1'b1;
  logic [31:0] m00_axis_tdata;
  logic        m00_axis_tlast;
  logic [3:0]  m00_axis_tstrb;

  fm_phase_discriminator #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .ANGLE_LSB             (16),
    .ANGLE_W               (16),
    .DECIM                 (DECIM)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(areset),
    .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tready(s00_axis_tready),
    .s00_axis_tdata (s00_axis_tdata),
    .s00_axis_tlast (s00_axis_tlast),
    .s00_axis_tstrb (s00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tready(m00_axis_tready),
    .m00_axis_tdata (m00_axis_tdata),
    .m00_axis_tlast (m00_axis_tlast),
    .m00_axis_tstrb (m00_axis_tstrb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    emit_cyc = -10;
  bit    rdy_rand = 1'b0;
  bit    rdy_fixed = 1'b1;

  // Reference model state: packet-level view of the angle stream.
  bit    m_prime = 1'b1;
  int    m_prev = 0;
  int    m_sum = 0;
  int    m_cnt = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wrap_angle(input int v);
    int m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m >= 32768) m -= 65536;
    return m;
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q -= 1;
    return q;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m00_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  end

  // Input monitor + reference model.
  always @(negedge clk) begin
    if (areset) begin
      m_prime = 1'b1;
      m_sum   = 0;
      m_cnt   = 0;
      exp_q.delete();
      emit_cyc <= -10;
    end else if (s00_axis_tvalid && s00_axis_tready) begin
      int a;
      a = int'($signed(s00_axis_tdata[31:16]));
      if (m_prime) begin
        m_prev = a;
        if (s00_axis_tlast) begin
          exp_q.push_back('{data: 32'd0, last: 1'b1});
          emit_cyc <= cyc;
        end else begin
          m_prime = 1'b0;
        end
      end else begin
        m_sum += wrap_angle(a - m_prev);
        m_prev = a;
        m_cnt++;
        if (m_cnt == DECIM || s00_axis_tlast) begin
          exp_q.push_back('{data: floor_div(m_sum, DECIM), last: s00_axis_tlast});
          emit_cyc <= cyc;
          m_sum = 0;
          m_cnt = 0;
          if (s00_axis_tlast) m_prime = 1'b1;
        end
      end
    end
  end

  // Output monitor.
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  always @(negedge clk) begin
    if (areset) begin
      hold_prev = 1'b0;
    end else begin
      if (cyc == emit_cyc + 1) begin
        check(m00_axis_tvalid === 1'b1, "latency_valid", {31'd0, m00_axis_tvalid}, 32'd1);
      end
      if (hold_prev) begin
        check(m00_axis_tvalid === 1'b1, "hold_valid", {31'd0, m00_axis_tvalid}, 32'd1);
        check(m00_axis_tdata === hold_data, "hold_data", m00_axis_tdata, hold_data);
        check(m00_axis_tlast === hold_last, "hold_last", {31'd0, m00_axis_tlast},
              {31'd0, hold_last});
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", m00_axis_tdata, 32'd0);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check(m00_axis_tdata === w.data, "word_data", m00_axis_tdata, w.data);
          check(m00_axis_tlast === w.last, "word_last", {31'd0, m00_axis_tlast},
                {31'd0, w.last});
        end
      end
      hold_prev = m00_axis_tvalid && !m00_axis_tready;
      hold_data = m00_axis_tdata;
      hold_last = m00_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ang, input bit last);
    bit hs;
    int tries;
    hs    = 1'b0;
    tries = 0;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = {ang, 16'($urandom)};
    s00_axis_tlast  = last;
    s00_axis_tstrb  = 4'($urandom);
    do begin
      @(negedge clk);
      hs = s00_axis_tready;
      tick();
      tries++;
    end while (!hs && tries < 200);
    if (!hs) check(1'b0, "input_timeout", {16'd0, ang}, 32'd0);
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
    s00_axis_tdata  = $urandom;
  endtask

  task automatic apply_reset(input bit with_valid);
    areset          = 1'b1;
    s00_axis_tvalid = with_valid;
    repeat (3) tick();
    areset          = 1'b0;
    s00_axis_tvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] d_saved;
    logic        l_saved;
    int          cur;
    int          wait_n;

    tick();
    apply_reset(1'b0);

    // Reset with a word pending and tvalid held high.
    rdy_fixed = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send(16'(i * 400), 1'b0);
    @(negedge clk);
    check(m00_axis_tvalid === 1'b1, "pending_before_reset", {31'd0, m00_axis_tvalid}, 32'd1);
    tick();
    apply_reset(1'b1);
    @(negedge clk);
    check(m00_axis_tvalid === 1'b0, "reset_valid", {31'd0, m00_axis_tvalid}, 32'd0);
    check(m00_axis_tdata === 32'd0, "reset_data", m00_axis_tdata, 32'd0);
    check(m00_axis_tlast === 1'b0, "reset_last", {31'd0, m00_axis_tlast}, 32'd0);
    check(m00_axis_tstrb === 4'hF, "tstrb", {28'd0, m00_axis_tstrb}, 32'hF);
    rdy_fixed = 1'b1;
    tick();

    // First sample only primes; then ramp of +100.
    send(16'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check(m00_axis_tvalid === 1'b0, "prime_no_output", {31'd0, m00_axis_tvalid}, 32'd0);
    end
    tick();
    for (int i = 1; i <= 8; i++) send(16'(i * 100), 1'b0);
    repeat (3) tick();

    // Wrap across +/-pi.
    apply_reset(1'b0);
    send(16'h7F00, 1'b0);
    send(16'h7FC0, 1'b0);
    send(16'h8080, 1'b0);
    send(16'h8140, 1'b0);
    send(16'h8200, 1'b0);
    repeat (3) tick();

    // Negative deltas flushed by tlast, then re-prime.
    apply_reset(1'b0);
    send(16'd300, 1'b0);
    send(16'd200, 1'b0);
    send(16'd100, 1'b1);
    for (int i = 0; i < 5; i++) send(16'(1000 + i * 10), 1'b0);
    repeat (3) tick();

    // Backpressure with a pending word and a waiting sample.
    apply_reset(1'b0);
    rdy_fixed = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send(16'(i * 4), 1'b0);
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = {16'd20, 16'h1234};
    s00_axis_tlast  = 1'b0;
    @(negedge clk);
    d_saved = m00_axis_tdata;
    l_saved = m00_axis_tlast;
    check(d_saved === 32'd4, "bp_pending_data", d_saved, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(s00_axis_tready === 1'b0, "bp_in_ready", {31'd0, s00_axis_tready}, 32'd0);
      check(m00_axis_tdata === d_saved, "bp_data_stable", m00_axis_tdata, d_saved);
      check(m00_axis_tlast === l_saved, "bp_last_stable", {31'd0, m00_axis_tlast},
            {31'd0, l_saved});
    end
    tick();
    rdy_fixed = 1'b1;
    send(16'd20, 1'b0);
    for (int i = 6; i < 9; i++) send(16'(i * 4), 1'b0);
    repeat (3) tick();

    // Single-sample packet, then reset mid-group.
    apply_reset(1'b0);
    send(16'd777, 1'b1);
    send(16'd0, 1'b0);
    send(16'd50, 1'b0);
    send(16'd100, 1'b0);
    apply_reset(1'b0);
    for (int i = 0; i < 5; i++) send(16'(i * 40), 1'b0);
    repeat (3) tick();

    // Randomized traffic with random sink backpressure.
    apply_reset(1'b0);
    rdy_rand = 1'b1;
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur = int'($urandom_range(0, 65535));
      else cur = cur + int'($urandom_range(0, 8000)) - 4000;
      send(16'(cur), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 50) begin
      tick();
      wait_n++;
    end
    repeat (2) tick();
    check(exp_q.size() == 0, "drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
